// File: rtl/detector_paso_pkg.sv
// -----------------------------------------------------------------------------
// detector_paso_pkg
// Shared definitions for the passage detector and its bench:
//   - default debounce length and counter width (1 ms at 100 MHz)
//   - FSM state encoding, also exported on ESTADO for debug
// -----------------------------------------------------------------------------
package detector_paso_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 100000;
    localparam int CNT_W_DEF           = 17;

    // E* states track an entry (A then B), S* states an exit (B then A).
    // ESPERA parks the FSM after an illegal two-bit jump until both clear.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        E1     = 3'd1,
        E2     = 3'd2,
        E3     = 3'd3,
        S1     = 3'd4,
        S2     = 3'd5,
        S3     = 3'd6,
        ESPERA = 3'd7
    } estado_t;

endpackage

// File: rtl/detector_paso_if.sv
// -----------------------------------------------------------------------------
// detector_paso_if
// Bundle of the detector's sensor inputs and event/debug outputs.
//   master : side that drives the raw sensors and watches the results
//   slave  : the detector itself
// -----------------------------------------------------------------------------
interface detector_paso_if;

    logic       btn1;
    logic       btn2;
    logic       entrada;
    logic       salida;
    logic       a_db;
    logic       b_db;
    logic [2:0] estado;

    modport master (
        output btn1, btn2,
        input  entrada, salida, a_db, b_db, estado
    );

    modport slave (
        input  btn1, btn2,
        output entrada, salida, a_db, b_db, estado
    );

endinterface

// File: rtl/detector_paso_antirebote.sv
// -----------------------------------------------------------------------------
// antirebote
// One sensor channel: 2-flop synchronizer followed by a counting debouncer.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   raw  - raw, asynchronous, bouncing sensor input
//   db   - debounced level
// The level flips only after DEBOUNCE_CYCLES consecutive cycles in which the
// synchronized input disagrees with it; any agreeing cycle restarts the count.
// -----------------------------------------------------------------------------
module antirebote #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             db_q,    db_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        db_d    = db_q;
        if (sync2_q != db_q) begin
            // The last mismatching cycle toggles instead of counting on.
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/detector_paso.sv
// -----------------------------------------------------------------------------
// detector_paso
// Two-sensor passage detector. Sensor A and B are debounced, then an FSM
// follows the Gray-style sequence of AB={A_DB,B_DB}:
//   entry: 00 -> 10 -> 11 -> 01 -> 00   => one-cycle ENTRADA pulse
//   exit : 00 -> 01 -> 11 -> 10 -> 00   => one-cycle SALIDA pulse
// Ports:
//   CLK, RST      - clock, asynchronous active-high reset
//   BTN1, BTN2    - raw sensors A and B
//   ENTRADA       - registered entry pulse
//   SALIDA        - registered exit pulse
//   A_DB, B_DB    - debounced sensor levels
//   ESTADO        - current FSM state (debug)
// -----------------------------------------------------------------------------
module detector_paso
    import detector_paso_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN1,
    input  logic       BTN2,
    output logic       ENTRADA,
    output logic       SALIDA,
    output logic       A_DB,
    output logic       B_DB,
    output logic [2:0] ESTADO
);

    // Bit 1 is sensor A, bit 0 sensor B, so db_vec reads directly as AB.
    logic [1:0] raw_vec;
    logic [1:0] db_vec;

    assign raw_vec = {BTN1, BTN2};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_canal
            antirebote #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_antirebote (
                .clk (CLK),
                .rst (RST),
                .raw (raw_vec[gi]),
                .db  (db_vec[gi])
            );
        end
    endgenerate

    estado_t    state_q, state_d;
    logic       entrada_q, entrada_d;
    logic       salida_q, salida_d;
    logic [1:0] ab;

    assign ab = db_vec;

    // In each sequence state the AB value of that state holds position, the
    // two one-bit neighbours move forward/back, and the remaining value is a
    // two-bit jump that parks the FSM in ESPERA.
    always_comb begin
        state_d   = state_q;
        entrada_d = 1'b0;
        salida_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = E1;
                    2'b01:   state_d = S1;
                    2'b11:   state_d = ESPERA;
                    default: state_d = IDLE;
                endcase
            end
            E1: begin
                case (ab)
                    2'b11:   state_d = E2;
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = ESPERA;
                    default: state_d = E1;
                endcase
            end
            E2: begin
                case (ab)
                    2'b01:   state_d = E3;
                    2'b10:   state_d = E1;
                    2'b00:   state_d = ESPERA;
                    default: state_d = E2;
                endcase
            end
            E3: begin
                case (ab)
                    2'b00: begin
                        state_d   = IDLE;
                        entrada_d = 1'b1;
                    end
                    2'b11:   state_d = E2;
                    2'b10:   state_d = ESPERA;
                    default: state_d = E3;
                endcase
            end
            S1: begin
                case (ab)
                    2'b11:   state_d = S2;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = ESPERA;
                    default: state_d = S1;
                endcase
            end
            S2: begin
                case (ab)
                    2'b10:   state_d = S3;
                    2'b01:   state_d = S1;
                    2'b00:   state_d = ESPERA;
                    default: state_d = S2;
                endcase
            end
            S3: begin
                case (ab)
                    2'b00: begin
                        state_d  = IDLE;
                        salida_d = 1'b1;
                    end
                    2'b11:   state_d = S2;
                    2'b01:   state_d = ESPERA;
                    default: state_d = S3;
                endcase
            end
            ESPERA: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            entrada_q <= 1'b0;
            salida_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            entrada_q <= entrada_d;
            salida_q  <= salida_d;
        end
    end

    assign ENTRADA = entrada_q;
    assign SALIDA  = salida_q;
    assign A_DB    = db_vec[1];
    assign B_DB    = db_vec[0];
    assign ESTADO  = state_q;

endmodule

// File: tb/tb_detector_paso.sv
// -----------------------------------------------------------------------------
// tb_detector_paso
// Directed scenarios followed by random sensor activity. Every cycle the DUT
// outputs are compared with a reference model that describes debouncing as
// "DEBOUNCE_CYCLES consecutive disagreeing synchronized samples" and the
// passage logic as a signed step count around the 4-position cycle
// 00,10,11,01: +4 is an entry, -4 an exit, a 2-position jump is illegal.
// -----------------------------------------------------------------------------
module tb_detector_paso;
    import detector_paso_pkg::*;

    localparam int D  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    detector_paso_if bus ();

    detector_paso #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .BTN1    (bus.btn1),
        .BTN2    (bus.btn2),
        .ENTRADA (bus.entrada),
        .SALIDA  (bus.salida),
        .A_DB    (bus.a_db),
        .B_DB    (bus.b_db),
        .ESTADO  (bus.estado)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]        s1;       // first sync stage, [1]=A [0]=B
        logic [1:0]        s2;       // second sync stage
        logic [D-1:0]      hist_a;   // last D synchronized samples of A
        logic [D-1:0]      hist_b;
        logic [1:0]        lvl;      // debounced AB
        logic [1:0]        ab_prev;  // AB the passage tracker last saw
        logic              espera;
        logic signed [3:0] d;        // signed step count from 00
        logic              ent;
        logic              sal;
    } model_t;

    model_t m;

    function automatic int gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic model_t model_next(input model_t c, input logic [1:0] raw);
        model_t n;
        int     step;
        int     dd;
        n     = c;
        n.ent = 1'b0;
        n.sal = 1'b0;
        n.hist_a = {c.hist_a[D-2:0], c.s2[1]};
        n.hist_b = {c.hist_b[D-2:0], c.s2[0]};
        if (n.hist_a == {D{~c.lvl[1]}}) n.lvl[1] = ~c.lvl[1];
        if (n.hist_b == {D{~c.lvl[0]}}) n.lvl[0] = ~c.lvl[0];
        n.s2 = c.s1;
        n.s1 = raw;
        step      = (gray_pos(c.lvl) - gray_pos(c.ab_prev)) & 3;
        n.ab_prev = c.lvl;
        if (c.espera) begin
            if (c.lvl == 2'b00) begin
                n.espera = 1'b0;
                n.d      = '0;
            end
        end else if (step == 2) begin
            n.espera = 1'b1;
        end else if (step != 0) begin
            dd = int'(c.d) + ((step == 1) ? 1 : -1);
            if (dd == 4) begin
                n.ent = 1'b1;
                dd    = 0;
            end else if (dd == -4) begin
                n.sal = 1'b1;
                dd    = 0;
            end
            n.d = 4'(dd);
        end
        return n;
    endfunction

    function automatic logic [7:0] exp_estado(input model_t c);
        if (c.espera)   return 8'd7;
        if (c.d > 0)    return 8'(int'(c.d));
        if (c.d < 0)    return 8'(3 - int'(c.d));
        return 8'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_next(m, {bus.btn1, bus.btn2});
    end

    // ---------------- checking ----------------
    int checks  = 0;
    int errors  = 0;
    int ent_cnt = 0;
    int sal_cnt = 0;
    int ent_idx = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("a_db",    8'(bus.a_db),    8'(m.lvl[1]));
        chk("b_db",    8'(bus.b_db),    8'(m.lvl[0]));
        chk("estado",  8'(bus.estado),  exp_estado(m));
        chk("entrada", 8'(bus.entrada), 8'(m.ent));
        chk("salida",  8'(bus.salida),  8'(m.sal));
        if (bus.entrada === 1'b1) ent_cnt++;
        if (bus.salida === 1'b1)  sal_cnt++;
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        bus.btn1 = ab[1];
        bus.btn2 = ab[0];
        ent_idx  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.entrada === 1'b1 && ent_idx == 0) ent_idx = i;
        end
        $display("hold AB=%b %0d cycles: estado=%0d ent=%0d sal=%0d", ab, n, bus.estado, ent_cnt, sal_cnt);
    endtask

    task automatic clear_counts();
        ent_cnt = 0;
        sal_cnt = 0;
    endtask

    initial begin
        bus.btn1 = 1'b0;
        bus.btn2 = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_estado",  8'(bus.estado),  8'd0);
        chk("rst_entrada", 8'(bus.entrada), 8'd0);
        chk("rst_salida",  8'(bus.salida),  8'd0);
        chk("rst_a_db",    8'(bus.a_db),    8'd0);
        chk("rst_b_db",    8'(bus.b_db),    8'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(2'b00, 5);

        // Clean entry sequence
        clear_counts();
        hold(2'b10, 20);
        hold(2'b11, 20);
        hold(2'b01, 20);
        hold(2'b00, 20);
        chk("entry_count",   8'(ent_cnt), 8'd1);
        chk("entry_latency", 8'(ent_idx), 8'd7);
        chk("entry_no_sal",  8'(sal_cnt), 8'd0);

        // Clean exit sequence
        clear_counts();
        hold(2'b01, 20);
        hold(2'b11, 20);
        hold(2'b10, 20);
        hold(2'b00, 20);
        chk("exit_count",  8'(sal_cnt), 8'd1);
        chk("exit_no_ent", 8'(ent_cnt), 8'd0);

        // Aborted sequences
        clear_counts();
        hold(2'b10, 20);
        hold(2'b00, 20);
        hold(2'b10, 20);
        hold(2'b11, 20);
        hold(2'b10, 20);
        hold(2'b00, 20);
        chk("abort_pulses", 8'(ent_cnt + sal_cnt), 8'd0);
        chk("abort_idle",   8'(bus.estado),        8'd0);

        // Simultaneous step -> ESPERA
        clear_counts();
        hold(2'b11, 20);
        chk("espera_state", 8'(bus.estado), 8'd7);
        hold(2'b00, 20);
        chk("espera_idle",   8'(bus.estado),        8'd0);
        chk("espera_pulses", 8'(ent_cnt + sal_cnt), 8'd0);

        // Short glitch on A must not reach the debounced level
        hold(2'b10, 3);
        hold(2'b00, 20);
        chk("glitch_a_db",   8'(bus.a_db),   8'd0);
        chk("glitch_estado", 8'(bus.estado), 8'd0);

        // Reset in the middle of an entry (state E3)
        clear_counts();
        hold(2'b10, 20);
        hold(2'b11, 20);
        hold(2'b01, 20);
        chk("pre_rst_e3", 8'(bus.estado), 8'd3);
        rst      = 1'b1;
        bus.btn1 = 1'b0;
        bus.btn2 = 1'b0;
        #1;
        chk("rst_mid_estado",  8'(bus.estado),  8'd0);
        chk("rst_mid_entrada", 8'(bus.entrada), 8'd0);
        chk("rst_mid_b_db",    8'(bus.b_db),    8'd0);
        hold(2'b00, 3);
        rst = 1'b0;
        hold(2'b00, 20);
        chk("rst_mid_no_ent", 8'(ent_cnt), 8'd0);

        // Random sensor activity, including bounces shorter than the window
        clear_counts();
        for (int k = 0; k < 200; k++) begin
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
        end
        hold(2'b00, 20);
        chk("random_idle", 8'(bus.estado), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/detector_paso.md
DETECTOR_PASO -- requirements
Module: detector_paso

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning consecutive stable clock cycles required before a debounced level changes (1 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 17, meaning debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port CLK, input, 1 bit: single system clock, rising-edge active.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port BTN1, input, 1 bit: raw sensor A, asynchronous to CLK, bouncing.
REQ-006 SHALL have port BTN2, input, 1 bit: raw sensor B, asynchronous to CLK, bouncing.
REQ-007 SHALL have port ENTRADA, output, 1 bit: one-cycle pulse on a completed entry sequence; feeds the counter increment.
REQ-008 SHALL have port SALIDA, output, 1 bit: one-cycle pulse on a completed exit sequence; feeds the counter decrement.
REQ-009 SHALL have port A_DB, output, 1 bit: debounced level of sensor A.
REQ-010 SHALL have port B_DB, output, 1 bit: debounced level of sensor B.
REQ-011 SHALL have port ESTADO, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer before debouncing.
REQ-013 SHALL keep, per channel, a counter that clears whenever the synchronized input equals the debounced level, and increments otherwise.
REQ-014 SHALL toggle the debounced level, and clear the counter, on the edge where the counter reaches DEBOUNCE_CYCLES-1; any mismatch-free cycle before that restarts the count.
REQ-015 SHALL therefore give a clean raw step a latency of 2+DEBOUNCE_CYCLES cycles to A_DB/B_DB, plus 1 cycle to ENTRADA/SALIDA.
REQ-016 SHALL encode the FSM states as IDLE=0, E1=1, E2=2, E3=3, S1=4, S2=5, S3=6, ESPERA=7; {A_DB,B_DB} is abbreviated AB.
REQ-017 SHALL transition from IDLE on AB=10 to E1, on AB=01 to S1, on AB=11 to ESPERA, and stay in IDLE on AB=00.
REQ-018 SHALL apply the entry path: E1 on 11 -> E2, on 00 -> IDLE; E2 on 01 -> E3, on 10 -> E1; E3 on 00 -> IDLE with ENTRADA, on 11 -> E2.
REQ-019 SHALL apply the exit path: S1 on 11 -> S2, on 00 -> IDLE; S2 on 10 -> S3, on 01 -> S1; S3 on 00 -> IDLE with SALIDA, on 11 -> S2.
REQ-020 SHALL treat every other AB value in E1..S3 (a two-bit jump) as illegal, go to ESPERA, and emit no pulse.
REQ-021 SHALL stay in ESPERA until AB=00, then go to IDLE with no pulse.
REQ-022 SHALL make ENTRADA and SALIDA registered, high for exactly one cycle, and never high together.
REQ-023 SHALL emit at most one pulse per return to AB=00.

Reset
REQ-024 SHALL, while RST is high, force: synchronizer flops 0, counters 0, A_DB=0, B_DB=0, state IDLE (ESTADO=0), ENTRADA=0, SALIDA=0.
REQ-025 SHALL abandon any partial sequence when RST asserts mid-sequence, with no pulse during or after reset.
REQ-026 SHALL, after RST deasserts, require a full fresh sequence from IDLE.

Structure
REQ-027 SHALL place the state encodings and the default DEBOUNCE_CYCLES in a shared package used by detector_paso and its bench.
REQ-028 SHALL implement the synchronizer and debouncer as sub-module antirebote, instantiated twice (one per channel).

Verification (all scenarios with DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover: AB 00->10->11->01->00, each held 20 cycles -> exactly one ENTRADA pulse, arriving 7 cycles after the final step; SALIDA stays 0.
REQ-030 SHALL cover: AB 00->01->11->10->00 -> exactly one SALIDA pulse; ENTRADA stays 0.
REQ-031 SHALL cover: 00->10->00, and also 00->10->11->10->00 -> no pulse; ESTADO returns to 0.
REQ-032 SHALL cover: simultaneous 00->11->00 -> ESTADO=7 then 0; no pulse.
REQ-033 SHALL cover: a BTN1 glitch of 3 cycles in IDLE -> A_DB stays 0 and ESTADO stays 0.
REQ-034 SHALL cover: RST pulse while in E3 -> ESTADO=0 immediately; a following AB=00 produces no ENTRADA.
